// File: rtl/dif_radix2_64p_da_ctrl.sv
// Fill/drain sequencer for the 64-point DIF arranger: writes a frame row-wise, reads it back transposed,
// and delays valid/sop/eop by the arranger read latency. in_ready drops for the whole drain phase.
module dif_radix2_64p_da_ctrl #(
  parameter int RF_DEPTH   = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sop,
  output logic                in_ready,
  output logic [RF_DEPTH-1:0] wen_ctrl,
  output logic [2:0]          waddr_ctrl,
  output logic [RF_DEPTH-1:0] ren_ctrl,
  output logic [2:0]          raddr_ctrl,
  output logic                out_valid,
  output logic                out_sop,
  output logic                out_eop,
  output logic                sync_err
);

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [RF_DEPTH-1:0] ONE = RF_DEPTH'(1);

  state_t                state, state_nxt;
  logic [5:0]            wcnt, wcnt_nxt;
  logic [5:0]            rcnt, rcnt_nxt;
  logic                  acc, resync;
  logic                  issue, issue_sop, issue_eop;
  logic [RD_LATENCY-1:0] vld_pipe, sop_pipe, eop_pipe;

  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    rcnt_nxt   = rcnt;
    in_ready   = (state == FILL);
    acc        = in_valid & in_ready;
    resync     = acc & in_sop & (wcnt != 6'd0);
    wen_ctrl   = '0;
    waddr_ctrl = wcnt[5:3];
    ren_ctrl   = '0;
    raddr_ctrl = 3'd0;
    issue      = (state == DRAIN);
    issue_sop  = issue & (rcnt == 6'd0);
    issue_eop  = issue & (rcnt == 6'd63);

    // A mid-frame sop restarts the frame with this sample as index 0.
    if (resync) begin
      wen_ctrl   = ONE;
      waddr_ctrl = 3'd0;
      wcnt_nxt   = 6'd1;
    end else if (acc) begin
      wen_ctrl = ONE << wcnt[2:0];
      wcnt_nxt = wcnt + 6'd1;
      if (wcnt == 6'd63) begin
        state_nxt = DRAIN;
      end
    end

    if (state == DRAIN) begin
      ren_ctrl   = ONE << rcnt[5:3];
      raddr_ctrl = rcnt[2:0];
      rcnt_nxt   = rcnt + 6'd1;
      if (rcnt == 6'd63) begin
        state_nxt = FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      wcnt     <= 6'd0;
      rcnt     <= 6'd0;
      sync_err <= 1'b0;
      vld_pipe <= '0;
      sop_pipe <= '0;
      eop_pipe <= '0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      rcnt        <= rcnt_nxt;
      sync_err    <= sync_err | resync;
      vld_pipe[0] <= issue;
      sop_pipe[0] <= issue_sop;
      eop_pipe[0] <= issue_eop;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sop_pipe[i] <= sop_pipe[i-1];
        eop_pipe[i] <= eop_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[RD_LATENCY-1];
  assign out_sop   = sop_pipe[RD_LATENCY-1];
  assign out_eop   = eop_pipe[RD_LATENCY-1];

endmodule
